// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path.
//   tx_state_e         - transmit feeder FSM states (fixed encoding, visible on debug taps)
//   TxWidthDefault     - default byte width, shared with uart_core tx_data
//   BusyTimeoutDefault - default cycles to wait for tx_busy after a request
package uart_pkg;

  localparam int unsigned TxWidthDefault     = 8;
  localparam int unsigned BusyTimeoutDefault = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StReq      = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count and synchronous clear.
//   clk, rst_n        - clock, asynchronous active-low reset
//   clear             - synchronous flush; wins over a same-cycle push
//   wr_data/wr_valid  - producer side; wr_ready = !full (no look-ahead on pop)
//   pop / rd_data     - consumer side; rd_data is the current head entry
//   count/empty/full  - occupancy, flags decoded from the registered count
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = TxWidthDefault,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop_ok;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign pop_ok   = pop && !empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries covered by count are ever read out.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffered front end that paces bytes into uart_core.
//   clk, rst_n        - clock, asynchronous active-low reset
//   clear             - flush FIFO and overflow flag; an in-flight frame completes
//   wr_data/wr_valid/wr_ready - producer byte stream
//   tx_data/tx_req    - byte and one-cycle request towards uart_core
//   tx_busy           - core is transmitting
//   count/empty/full  - FIFO occupancy
//   overflow          - sticky: a write was attempted while full
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = TxWidthDefault,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = BusyTimeoutDefault
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_req,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e        state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [WIDTH-1:0] tx_data_q, head;
  logic             overflow_q;
  logic             pop;

  uart_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .pop      (pop),
    .rd_data  (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    unique case (state_q)
      // A busy core in IDLE means a frame was started elsewhere; do not pop.
      StIdle: begin
        if (!empty && !tx_busy) begin
          state_d = StReq;
          pop     = 1'b1;
        end
      end
      StReq: begin
        state_d = StWaitBusy;
        tmo_d   = '0;
      end
      // No busy within BUSY_TIMEOUT cycles: treat the request as dropped.
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TmoW'(BUSY_TIMEOUT)) state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (pop) tx_data_q <= head;
      if (clear)                 overflow_q <= 1'b0;
      else if (wr_valid && full) overflow_q <= 1'b1;
    end
  end

  assign tx_req   = (state_q == StReq);
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int unsigned WIDTH        = 8;
  localparam int unsigned DEPTH        = 8;
  localparam int unsigned BUSY_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n, clear, wr_valid, wr_ready, tx_req, tx_busy;
  logic       empty, full, overflow;
  logic [7:0] wr_data, tx_data;
  logic [3:0] count;

  uart_tx_feeder #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_busy  (tx_busy),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Core model: busy for busy_len cycles after each request (0 = never busy).
  int busy_len   = 10;
  bit force_busy = 1'b0;
  int busy_cnt   = 0;
  bit req_seen   = 1'b0;

  // Reference model: queue of bytes plus the phase of the frame in flight.
  logic [7:0] mq[$];
  bit         m_req, m_in_frame, m_ovf;
  int         m_await;
  logic [7:0] m_data;

  // Requests observed on the DUT: byte and cycle.
  logic [7:0] log_data[$];
  int         log_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req      = 1'b0;
    m_in_frame = 1'b0;
    m_ovf      = 1'b0;
    m_await    = 0;
    m_data     = 8'h00;
  endtask

  // One clock edge of behaviour, from the inputs stable before the edge.
  task automatic model_update();
    int pre;
    pre = mq.size();
    if (m_req) begin
      m_req   = 1'b0;
      m_await = BUSY_TIMEOUT;
    end else if (m_await > 0) begin
      if (tx_busy) begin
        m_await    = 0;
        m_in_frame = 1'b1;
      end else begin
        m_await--;
      end
    end else if (m_in_frame) begin
      if (!tx_busy) m_in_frame = 1'b0;
    end else if (pre > 0 && !tx_busy) begin
      m_data = mq.pop_front();
      m_req  = 1'b1;
    end
    if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (wr_valid) begin
      if (pre < int'(DEPTH)) mq.push_back(wr_data);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    cyc++;
    #1;
    if (busy_cnt > 0) busy_cnt--;
    if (req_seen && busy_len > 0) busy_cnt = busy_len;
    req_seen = tx_req;
    tx_busy  = force_busy || (busy_cnt > 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (!wr_ready && guard < 200) begin
      step();
      guard++;
    end
    if (!wr_ready) chk("push_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic force_push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int k;
    k = 0;
    while (log_data.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("req_count", 32'(log_data.size()), 32'(n));
  endtask

  task automatic check_log(input string name, input int first, input logic [7:0] base,
                           input int n);
    for (int i = 0; i < n; i++) begin
      if (log_data.size() > first + i)
        chk(name, 32'(log_data[first + i]), 32'(base + 8'(i)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_req"},   32'(tx_req),   32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("tx_req",   32'(tx_req),   32'(m_req));
      chk("tx_data",  32'(tx_data),  32'(m_data));
      chk("count",    32'(count),    32'(mq.size()));
      chk("empty",    32'(empty),    32'(mq.size() == 0));
      chk("full",     32'(full),     32'(mq.size() == DEPTH));
      chk("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (tx_req) begin
        log_data.push_back(tx_data);
        log_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tx_busy  = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();

    // Single byte: request one cycle after the accepting edge.
    busy_len = 10;
    push_byte(8'hA5);
    chk("single_count", 32'(count), 32'd1);
    step();
    chk("single_req",  32'(tx_req),  32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    repeat (20) step();
    chk("single_pulses", 32'(log_data.size()), 32'd1);
    chk("single_count_end", 32'(count), 32'd0);

    // Burst of eight against a 10-cycle busy core.
    log_data.delete();
    log_cyc.delete();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    wait_reqs(8, 300);
    check_log("burst_order", 0, 8'h01, 8);
    repeat (15) step();

    // Overflow: core held busy, nine writes.
    force_busy = 1'b1;
    step();
    for (int i = 0; i < 8; i++) force_push(8'h80 + 8'(i));
    chk("ovf_full",   32'(full),     32'd1);
    chk("ovf_count",  32'(count),    32'd8);
    chk("ovf_ready9", 32'(wr_ready), 32'd0);
    force_push(8'h88);
    chk("ovf_flag",   32'(overflow), 32'd1);
    chk("ovf_count9", 32'(count),    32'd8);
    busy_len   = 2;
    force_busy = 1'b0;
    wait_reqs(16, 200);
    check_log("ovf_drain", 8, 8'h80, 8);
    repeat (10) step();
    chk("ovf_no_ninth", 32'(log_data.size()), 32'd16);
    chk("ovf_sticky",   32'(overflow),        32'd1);
    force_busy = 1'b1;
    step();
    for (int i = 0; i < 3; i++) force_push(8'hC0 + 8'(i));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_count",    32'(count),    32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    force_busy = 1'b0;
    repeat (10) step();
    chk("clear_no_req", 32'(log_data.size()), 32'd16);

    // Timeout: busy never rises; next byte follows 6 cycles later.
    busy_len = 0;
    log_data.delete();
    log_cyc.delete();
    push_byte(8'h11);
    push_byte(8'h22);
    wait_reqs(2, 100);
    check_log("tmo_order", 0, 8'h11, 1);
    check_log("tmo_order", 1, 8'h22, 1);
    if (log_cyc.size() >= 2) chk("tmo_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd6);
    repeat (10) step();
    chk("tmo_no_extra", 32'(log_data.size()), 32'd2);

    // Wrap-around: 20 bytes, pushes overlapping pops.
    busy_len = 1;
    log_data.delete();
    log_cyc.delete();
    for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i));
    wait_reqs(20, 400);
    check_log("wrap_order", 0, 8'h40, 20);
    repeat (10) step();

    // Reset in the middle of a frame with three bytes queued.
    busy_len = 10;
    log_data.delete();
    log_cyc.delete();
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
    chk("rst_queued", 32'(count), 32'd3);
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    busy_cnt = 0;
    req_seen = 1'b0;
    tx_busy  = 1'b0;
    chk("rst_reqs_before", 32'(log_data.size()), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("rst_no_req", 32'(log_data.size()), 32'd1);
    push_byte(8'h77);
    wait_reqs(2, 50);
    check_log("rst_new", 1, 8'h77, 1);
    repeat (15) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
